bus_mem_responder: RTL

Bus-side memory responder. It services the word read and write requests issued onto the data bus by the CPU memory manager. It holds a word-addressed storage array and asserts bus_full while a request is in flight. It returns read data, or a write acknowledge, after a fixed programmable latency. It sits between the shared bus and the backing SRAM model and is the target end of the manager's request/bus_full handshake.

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/mem_sram_array.sv | 28 ++
 rtl/bus_mem_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the bus memory responder
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } resp_state_t;

  localparam int         WORD_BYTES   = 4;
  localparam logic [3:0] SEL_ALL      = 4'hF;
  localparam int         LAT_CNT_BITS = 4;

  // Counter preload on accept; the WAIT state runs while counting down to zero.
  function automatic logic [LAT_CNT_BITS-1:0] lat_load(input int latency);
    return (latency > 1) ? LAT_CNT_BITS'(latency - 2) : '0;
  endfunction

endpackage

// File: rtl/mem_sram_array.sv
// rtl/mem_sram_array.sv - word-addressed 32-bit storage, per-byte write enable, registered read
module mem_sram_array
  import mem_bus_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                  clk,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [WORD_BYTES-1:0] byte_we,
  input  logic [31:0]           wdata,
  input  logic                  re,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(2**ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (byte_we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - bus target that services word reads/writes with fixed latency
module bus_mem_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [3:0]  sel_in,
  input  logic        read_req,
  input  logic        write_req,
  output logic        bus_full,
  output logic [31:0] rdata_out,
  output logic        ack,
  output logic        err
);

  resp_state_t             state, state_next;
  logic [LAT_CNT_BITS-1:0] cnt, cnt_next;
  logic [31:0]             addr_q, wdata_q;
  logic [3:0]              sel_q;
  logic                    rd_q, wr_q;
  logic                    accept, enter_resp;
  logic [31:0]             req_addr, req_wdata;
  logic [3:0]              req_sel;
  logic                    req_rd, req_wr, req_err, lat_err;
  logic [3:0]              sram_be;
  logic                    sram_re;
  logic [31:0]             sram_rdata;

  function automatic logic bad_req(input logic [31:0] a, input logic r, input logic w);
    return (a[1:0] != 2'b00) || (a[31:ADDR_BITS+2] != '0) || (r && w);
  endfunction

  assign accept = (state == IDLE) && (read_req || write_req);

  // With LATENCY=1 the RESPOND entry edge is the accepting edge, so live inputs apply there.
  always_comb begin
    req_addr  = addr_q;
    req_wdata = wdata_q;
    req_sel   = sel_q;
    req_rd    = rd_q;
    req_wr    = wr_q;
    if (state == IDLE) begin
      req_addr  = addr_in;
      req_wdata = wdata_in;
      req_sel   = sel_in;
      req_rd    = read_req;
      req_wr    = write_req;
    end
  end

  assign req_err = bad_req(req_addr, req_rd, req_wr);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESPOND;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = lat_load(LATENCY);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = RESPOND;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt - LAT_CNT_BITS'(1);
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        addr_q  <= addr_in;
        wdata_q <= wdata_in;
        sel_q   <= sel_in;
        rd_q    <= read_req;
        wr_q    <= write_req;
      end
    end
  end

  // Reset on the entry edge must also suppress the commit.
  assign sram_be = (enter_resp && req_wr && !req_err && !rst) ? req_sel : 4'b0000;
  assign sram_re = enter_resp && req_rd && !req_err;

  mem_sram_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .addr    (req_addr[ADDR_BITS+1:2]),
    .byte_we (sram_be),
    .wdata   (req_wdata),
    .re      (sram_re),
    .rdata   (sram_rdata)
  );

  assign lat_err   = bad_req(addr_q, rd_q, wr_q);
  assign bus_full  = (state != IDLE);
  assign ack       = (state == RESPOND);
  assign err       = ack && lat_err;
  assign rdata_out = (ack && rd_q && !lat_err) ? sram_rdata : 32'h0;

endmodule
